// File: rtl/alu_bist_pkg.sv
// Shared ALU control codes, BIST FSM states and the test vector record.
package alu_bist_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
    } vec_t;

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU self-test vector table; unused indices read as all zeros.
module alu_bist_rom
    import alu_bist_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output vec_t             vec
);

    localparam logic [31:0] VA = 32'h00BC614E;
    localparam logic [31:0] VB = 32'h05397FB1;
    localparam logic [31:0] MS = 32'h80000000;

    always_comb begin
        vec = '0;
        case (int'(idx))
            0: vec = '{VA, VB, ALU_ADD,  32'h05F5E0FF, 1'b0};
            1: vec = '{VA, VB, ALU_SUB,  32'hFB82E19D, 1'b0};
            2: vec = '{VA, VB, ALU_AND,  32'h00386100, 1'b0};
            3: vec = '{VA, VB, ALU_OR,   32'h05BD7FFF, 1'b0};
            4: vec = '{VA, VB, ALU_XOR,  32'h05851EFF, 1'b0};
            5: vec = '{VA, VB, ALU_SLT,  32'h00000001, 1'b0};
            6: vec = '{VA, VB, ALU_SLTU, 32'h00000001, 1'b0};
            7: vec = '{VA, VA, ALU_SUB,  32'h00000000, 1'b1};
            8: vec = '{MS, 32'd1, ALU_SLT,  32'h00000001, 1'b0};
            9: vec = '{MS, 32'd1, ALU_SLTU, 32'h00000000, 1'b1};
            default: vec = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: drives table vectors, waits, checks result/zero,
// and reports pass or the first failing vector.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int NUM_VEC       = 10,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDX_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] fail_index,
    output logic [31:0]      fail_result,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero
);

    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_VEC - 1);
    localparam logic [3:0]       SET_LD = 4'(SETTLE_CYCLES);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [3:0]       cnt, cnt_n;
    logic             busy_n, done_n, pass_n;
    logic [IDX_W-1:0] fail_index_n;
    logic [31:0]      fail_result_n;
    logic [31:0]      alu_a_n, alu_b_n;
    logic [3:0]       alu_ctrl_n;
    vec_t             vec;
    logic             mismatch;

    alu_bist_rom #(.IDX_W(IDX_W)) u_rom (
        .idx (idx),
        .vec (vec)
    );

    assign mismatch = {alu_zero, alu_result} != {vec.zero, vec.res};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_index  <= '0;
            fail_result <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            fail_index  <= fail_index_n;
            fail_result <= fail_result_n;
            alu_a       <= alu_a_n;
            alu_b       <= alu_b_n;
            alu_ctrl    <= alu_ctrl_n;
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        cnt_n         = cnt;
        busy_n        = busy;
        done_n        = done;
        pass_n        = pass;
        fail_index_n  = fail_index;
        fail_result_n = fail_result;
        alu_a_n       = alu_a;
        alu_b_n       = alu_b;
        alu_ctrl_n    = alu_ctrl;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_n        = 1'b0;
                    pass_n        = 1'b0;
                    fail_index_n  = '0;
                    fail_result_n = '0;
                    idx_n         = '0;
                    busy_n        = 1'b1;
                    state_n       = S_DRIVE;
                end
            end
            S_DRIVE: begin
                alu_a_n    = vec.a;
                alu_b_n    = vec.b;
                alu_ctrl_n = vec.ctrl;
                cnt_n      = SET_LD;
                state_n    = S_SETTLE;
            end
            S_SETTLE: begin
                cnt_n = cnt - 4'd1;
                // Treat a zero count as expired so the FSM never wraps.
                if (cnt <= 4'd1) begin
                    cnt_n   = '0;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    fail_index_n  = idx;
                    fail_result_n = alu_result;
                    pass_n        = 1'b0;
                    busy_n        = 1'b0;
                    done_n        = 1'b1;
                    state_n       = S_DONE;
                end else if (idx == LAST) begin
                    pass_n  = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_DRIVE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with injectable faults, two DUTs
// (settle 1 and 3), expected outcome derived from the vector table.
module tb_alu_bist;
    import alu_bist_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic        busy0, done0, pass0, zero0;
    logic [3:0]  fi0, c0;
    logic [31:0] fr0, a0, b0, r0;
    logic        busy1, done1, pass1, zero1;
    logic [3:0]  fi1, c1;
    logic [31:0] fr1, a1, b1, r1;

    int          fmode = 0;
    logic [3:0]  fop = 4'hF;
    logic [31:0] fmask = 32'd0;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] TA [10] = '{
        32'h00BC614E, 32'h00BC614E, 32'h00BC614E, 32'h00BC614E,
        32'h00BC614E, 32'h00BC614E, 32'h00BC614E, 32'h00BC614E,
        32'h80000000, 32'h80000000};
    localparam logic [31:0] TB [10] = '{
        32'h05397FB1, 32'h05397FB1, 32'h05397FB1, 32'h05397FB1,
        32'h05397FB1, 32'h05397FB1, 32'h05397FB1, 32'h00BC614E,
        32'h00000001, 32'h00000001};
    localparam logic [3:0] TC [10] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd5, 4'd6};
    localparam logic [31:0] TR [10] = '{
        32'h05F5E0FF, 32'hFB82E19D, 32'h00386100, 32'h05BD7FFF,
        32'h05851EFF, 32'h00000001, 32'h00000001, 32'h00000000,
        32'h00000001, 32'h00000000};
    localparam logic TZ [10] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // ALU under test, with fault modes: 1 SUB->ADD, 2 zero stuck 0, 3 xor on fop
    function automatic logic [32:0] alu_dut(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  c);
        logic [31:0] r;
        logic        z;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        if (fmode == 1 && c == 4'd1) r = a + b;
        if (fmode == 3 && c == fop) r = r ^ fmask;
        z = (fmode == 2) ? 1'b0 : (r == 32'd0);
        return {z, r};
    endfunction

    assign {zero0, r0} = alu_dut(a0, b0, c0);
    assign {zero1, r1} = alu_dut(a1, b1, c1);

    alu_bist dut0 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_index(fi0), .fail_result(fr0),
        .alu_a(a0), .alu_b(b0), .alu_ctrl(c0),
        .alu_result(r0), .alu_zero(zero0)
    );

    alu_bist #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_index(fi1), .fail_result(fr1),
        .alu_a(a1), .alu_b(b1), .alu_ctrl(c1),
        .alu_result(r1), .alu_zero(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input int s, output int cyc, output logic ps,
                         output logic [3:0] fi, output logic [31:0] fr);
        logic [32:0] o;
        logic        found;
        found = 1'b0;
        ps    = 1'b1;
        fi    = 4'd0;
        fr    = 32'd0;
        cyc   = 10 * (s + 2);
        for (int i = 0; i < 10; i++) begin
            o = alu_dut(TA[i], TB[i], TC[i]);
            if (!found && (o[31:0] !== TR[i] || o[32] !== TZ[i])) begin
                found = 1'b1;
                ps    = 1'b0;
                fi    = 4'(i);
                fr    = o[31:0];
                cyc   = (i + 1) * (s + 2);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
        chk({tag, "_pass0"}, {31'd0, pass0}, 32'd0);
        chk({tag, "_fi0"}, {28'd0, fi0}, 32'd0);
        chk({tag, "_fr0"}, fr0, 32'd0);
        chk({tag, "_a0"}, a0, 32'd0);
        chk({tag, "_b0"}, b0, 32'd0);
        chk({tag, "_c0"}, {28'd0, c0}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_a1"}, a1, 32'd0);
        chk({tag, "_fr1"}, fr1, 32'd0);
    endtask

    task automatic run(input string tag, input int restart_at,
                       input int reset_at);
        int          n, t0, t1, e0, e1;
        logic        ep0, ep1, aborted;
        logic [3:0]  ei0, ei1;
        logic [31:0] er0, er1;
        model(1, e0, ep0, ei0, er0);
        model(3, e1, ep1, ei1, er1);
        n = 0; t0 = -1; t1 = -1; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_on_start"}, {31'd0, busy0}, 32'd1);
        chk({tag, "_done_clr"}, {31'd0, done0}, 32'd0);
        while ((t0 < 0 || t1 < 0) && n < 200 && !aborted) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (reset) begin
                chk_zero({tag, "_rst"});
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                if (t0 < 0)
                    chk({tag, "_busy0"}, {31'd0, busy0}, {31'd0, n < e0});
                if (done0 && t0 < 0) t0 = n;
                if (done1 && t1 < 0) t1 = n;
                if (n == restart_at) start = 1'b1;
                if (n == reset_at) reset = 1'b1;
            end
        end
        if (!aborted) begin
            chk({tag, "_cycles0"}, t0, e0);
            chk({tag, "_cycles1"}, t1, e1);
            chk({tag, "_pass0"}, {31'd0, pass0}, {31'd0, ep0});
            chk({tag, "_fi0"}, {28'd0, fi0}, {28'd0, ei0});
            chk({tag, "_fr0"}, fr0, er0);
            chk({tag, "_pass1"}, {31'd0, pass1}, {31'd0, ep1});
            chk({tag, "_fi1"}, {28'd0, fi1}, {28'd0, ei1});
            chk({tag, "_fr1"}, fr1, er1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        fmode = 0;
        run("good", -1, -1);

        fmode = 1;
        run("subadd", -1, -1);
        chk("subadd_hold_ctrl", {28'd0, c0}, {28'd0, ALU_SUB});
        chk("subadd_hold_a", a0, TA[1]);
        chk("subadd_hold_b", b0, TB[1]);

        fmode = 2;
        run("zstuck", -1, -1);

        fmode = 0;
        run("midrst", -1, 13);
        run("after_rst", -1, -1);
        run("restart", 10, -1);

        for (int k = 0; k < 4; k++) begin
            fmode = ($urandom_range(0, 3) == 0) ? 0 : 3;
            fop   = 4'($urandom_range(0, 6));
            fmask = $urandom;
            if (fmask == 32'd0) fmask = 32'd1;
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run($sformatf("rand%0d", k), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Hardware built-in self-test engine on the ALU operand/control interface; it is the driving and checking end of that interface.
- On `start` it steps through a fixed vector table. For each vector it drives `alu_a`, `alu_b` and `alu_ctrl`, waits for the ALU output to settle, then compares `alu_result` and `alu_zero` against the expected values.
- It reports pass, or the first failing vector.
- Instantiated beside the single-cycle core's ALU, with a mux selecting BIST or datapath operands while `busy`.

Parameters:
- NUM_VEC, 10, number of table entries executed (1..16).
- SETTLE_CYCLES, 1, clock cycles between driving operands and sampling the result (1..15).
- IDX_W, 4, width of the vector index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- busy  out  1  high while a run is in progress (also the operand-mux select).
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  valid when `done`=1; 1 means all vectors matched.
- fail_index  out  IDX_W  index of the first mismatching vector; 0 if none.
- fail_result  out  32  `alu_result` captured at the first mismatch; 0 if none.
- alu_a  out  32  operand A to the ALU.
- alu_b  out  32  operand B to the ALU.
- alu_ctrl  out  4  ALUControl code to the ALU.
- alu_result  in  32  ALU Result.
- alu_zero  in  1  ALU Zero flag.

Behaviour:
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_index`=0, `fail_result`=0, `alu_a`=0, `alu_b`=0, `alu_ctrl`=0; FSM in IDLE; index=0; settle counter=0.
- FSM states:
  - IDLE: on `start`, clear `done`, `pass`, `fail_index` and `fail_result`; set index=0 and `busy`=1; go to DRIVE.
  - DRIVE (1 cycle): register the table entry at index onto `alu_a`/`alu_b`/`alu_ctrl`; load the settle counter with SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter each cycle; when it reaches 0, go to CHECK.
  - CHECK (1 cycle): compare `alu_result` against the expected result and `alu_zero` against the expected zero flag.
    - Mismatch: capture `fail_index` and `fail_result`; `pass`=0; go to DONE.
    - Match on the last vector (index == NUM_VEC-1): `pass`=1; go to DONE.
    - Match otherwise: index+1; go to DRIVE.
  - DONE: `busy`=0, `done`=1. A new `start` behaves as in IDLE.
- Latency per vector = SETTLE_CYCLES + 2 cycles. A full passing run with defaults takes NUM_VEC×3 = 30 cycles from the `start` edge to `done`=1.
- `start` while `busy`=1 is ignored; no restart.
- Operands hold their last driven values in DONE and IDLE; they are not re-zeroed.
- Compare is exact 32-bit equality plus equality of the zero flag; both must match.
- `reset` asserted mid-run: next edge returns all outputs to reset values and the FSM to IDLE; the partial run is discarded.
- `reset` and `start` in the same cycle: reset wins.
- Vector table, with A=0x00BC614E and B=0x05397FB1 unless noted (entry: op, expected result, expected zero):
  - 0: ADD 0000, 0x05F5E0FF, 0.
  - 1: SUB 0001, 0xFB82E19D, 0.
  - 2: AND 0010, 0x00386100, 0.
  - 3: OR 0011, 0x05BD7FFF, 0.
  - 4: XOR 0100, 0x05851EFF, 0.
  - 5: SLT 0101, 1, 0.
  - 6: SLTU 0110, 1, 0.
  - 7: SUB with A=B=0x00BC614E, 0, 1.
  - 8: SLT with A=0x80000000, B=1, 1, 0.
  - 9: SLTU with A=0x80000000, B=1, 0, 1.
  - Indices ≥ NUM_VEC are never read.

Decomposition:
- Shared header `alu_defs.vh`: ALUControl code constants (ADD, SUB, AND, OR, XOR, SLT, SLTU) and the FSM state encodings. The ALU and the ALU decoder use the same constants.
- One sub-module, `alu_bist_rom`: purely combinational index → {a, b, ctrl, exp_result, exp_zero}. An out-of-range index returns all zeros.

Test Plan:
- Correct ALU model, pulse `start` → `busy` for 30 cycles, then `done`=1, `pass`=1, `fail_index`=0, `fail_result`=0.
- Fault model forcing SUB to return A+B → `done`=1, `pass`=0, `fail_index`=1, `fail_result`=0x05F5E0FF; vectors 2..9 are never driven.
- Fault model with `alu_zero` stuck at 0 → fails at `fail_index`=7 with `fail_result`=0.
- `reset` pulsed during vector 4's SETTLE → next cycle all outputs are 0 and the FSM is in IDLE. A following `start` completes with `pass`=1.
- `start` pulsed again at cycle 10 of a run → ignored; completion is still 30 cycles after the first `start`. A `start` in DONE begins a second run and clears `done` on the next edge.
- SETTLE_CYCLES=3 → operands are stable for 3 cycles before each CHECK; a full run takes 50 cycles.
